memory_access_stage: RTL and testbench

- MEM-stage responder for the EX-stage outputs: consumes address (ALU result), store data, funct3, rd and the memory/writeback controls latched in the EX/MEM register.
- Runs a request/response handshake with a multi-cycle data memory and stalls the pipeline until the access completes.
- Forms byte strobes for stores and sign/zero-extends load data toward writeback.

---
 rtl/memory_access_stage.sv | 184 ++++++++++++++++++
 tb/tb_memory_access_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// MEM stage: data-memory request/response sequencing, store lane steering,
// load extraction and alignment/timeout fault reporting.
module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_result,
  input  logic [31:0] data2,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        memory_read_enable,
  input  logic        memory_write_enable,
  input  logic        regwrite_enable,
  input  logic        mux3_select,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data_out,
  output logic [31:0] ALU_result_out,
  output logic [4:0]  rd_out,
  output logic        regwrite_enable_out,
  output logic        mux3_select_out,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [TW-1:0]   timer;
  logic            access;
  logic            fault;
  logic            timer_last;
  logic            timeout_hit;
  logic            load_cap;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] load_ext;
  logic [3:0]      strb;

  assign access     = memory_read_enable | memory_write_enable;
  assign timer_last = (timer == TW'(TIMEOUT_CYCLES - 1));

  // Passthroughs toward writeback and the request address.
  assign ALU_result_out      = ALU_result;
  assign rd_out              = rd;
  assign mux3_select_out     = mux3_select;
  assign mem_addr            = {ALU_result[31:2], 2'b00};
  assign mem_req_valid       = (state == REQ);
  assign mem_we              = memory_write_enable;
  assign mem_wstrb           = memory_write_enable ? strb : 4'b0000;
  assign regwrite_enable_out = regwrite_enable & ~misaligned & ~bus_error;

  // Alignment and illegal-size detection for the instruction in EX/MEM.
  always_comb begin
    fault = 1'b0;
    if (funct3[1:0] == 2'b01 && ALU_result[0]) fault = 1'b1;
    if (funct3 == 3'b010 && ALU_result[1:0] != 2'b00) fault = 1'b1;
    if (memory_read_enable && (funct3 == 3'b011 || funct3[2:1] == 2'b11)) fault = 1'b1;
    if (memory_write_enable && (funct3[2] || funct3[1:0] == 2'b11)) fault = 1'b1;
    fault = fault & access;
  end

  // Store lane replication and byte enables.
  always_comb begin
    mem_wdata = data2;
    strb      = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        mem_wdata = {4{data2[7:0]}};
        strb      = 4'(4'b0001 << ALU_result[1:0]);
      end
      2'b01: begin
        mem_wdata = {2{data2[15:0]}};
        strb      = ALU_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        mem_wdata = data2;
        strb      = 4'b1111;
      end
    endcase
  end

  // Load lane selection with sign/zero extension.
  always_comb begin
    rd_byte  = mem_rdata[{ALU_result[1:0], 3'b000} +: 8];
    rd_half  = mem_rdata[{ALU_result[1], 4'b0000} +: 16];
    load_ext = mem_rdata;
    case (funct3)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_ext = {24'b0, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_ext = {16'b0, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state and combinational handshake outputs.
  always_comb begin
    state_next  = state;
    stall       = 1'b0;
    misaligned  = 1'b0;
    timeout_hit = 1'b0;
    load_cap    = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (fault) begin
            misaligned = 1'b1;
          end else begin
            stall      = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (timer_last) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end else if (mem_req_ready) begin
          state_next = RESP;
        end
      end
      RESP: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          load_cap   = memory_read_enable;
          state_next = DONE;
        end else if (timer_last) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Access timer: zero outside the bus phases, counts REQ/RESP cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (state == REQ || state == RESP) begin
      timer <= timer + TW'(1);
    end else begin
      timer <= '0;
    end
  end

  // Timeout flag, valid for the DONE cycle only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus_error <= 1'b0;
    else        bus_error <= timeout_hit;
  end

  // Load result capture on the read response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        load_data_out <= '0;
    else if (load_cap) load_data_out <= load_ext;
  end

endmodule

// File: tb/tb_memory_access_stage.sv
`timescale 1ns/1ps
// Directed bench for memory_access_stage with a transaction-level model.
module tb_memory_access_stage;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALU_result, data2, mem_rdata;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        memory_read_enable, memory_write_enable, regwrite_enable, mux3_select;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, load_data_out, ALU_result_out;
  logic [3:0]  mem_wstrb;
  logic [4:0]  rd_out;
  logic        regwrite_enable_out, mux3_select_out, stall, misaligned, bus_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder configuration: cfg_rl < 0 means never ready.
  int   cfg_rl = 0;
  int   cfg_vl = 0;
  logic stray_rv = 1'b0;
  int   r_state = 0;
  int   r_cnt = 0;

  // Model state: phase 0 idle, 1 bus access in flight, 2 completion cycle.
  int          m_ph = 0;
  int          m_cyc = 0;
  bit          m_acc = 0;
  bit          m_to = 0;
  logic [31:0] m_ld = '0;

  memory_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(rst_n),
    .ALU_result(ALU_result), .data2(data2), .funct3(funct3), .rd(rd),
    .memory_read_enable(memory_read_enable), .memory_write_enable(memory_write_enable),
    .regwrite_enable(regwrite_enable), .mux3_select(mux3_select),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .load_data_out(load_data_out),
    .ALU_result_out(ALU_result_out), .rd_out(rd_out),
    .regwrite_enable_out(regwrite_enable_out), .mux3_select_out(mux3_select_out),
    .stall(stall), .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_fault(input logic re, input logic we, input logic [2:0] f3,
                                 input logic [1:0] a);
    bit legal, aligned;
    if (!(re || we)) return 1'b0;
    if (we) legal = (f3 inside {3'b000, 3'b001, 3'b010});
    else    legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (f3[1:0])
      2'b01:   aligned = (a[0] == 1'b0);
      2'b10:   aligned = (a == 2'b00);
      default: aligned = 1'b1;
    endcase
    return !legal || !aligned;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    for (int b = 0; b < 4; b++) begin
      if (f3[1:0] == 2'b00)      s[b] = (b == int'(a));
      else if (f3[1:0] == 2'b01) s[b] = ((b / 2) == int'(a[1]));
      else                       s[b] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f3[1:0] == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] a,
                                        input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * int'(a));
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'b0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Memory responder: ready after cfg_rl request cycles, response cfg_vl cycles later.
  initial begin
    logic rv;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    forever begin
      @(negedge clk);
      rv = 1'b0;
      mem_req_ready = 1'b0;
      if (!rst_n || !stall) begin
        r_state = 0;
        r_cnt   = 0;
      end else begin
        case (r_state)
          0: if (mem_req_valid) begin
               if (cfg_rl >= 0 && r_cnt >= cfg_rl) begin
                 mem_req_ready = 1'b1;
                 r_state = 1;
                 r_cnt   = 0;
               end else begin
                 r_cnt++;
               end
             end
          1: if (r_cnt >= cfg_vl) begin
               rv = 1'b1;
               r_state = 2;
             end else begin
               r_cnt++;
             end
          default: ;
        endcase
      end
      mem_rvalid = rv | stray_rv;
    end
  end

  // Per-cycle compare against the transaction model, then advance the model.
  initial begin
    bit acc, flt;
    logic e_stall, e_mis, e_rv, e_be, e_rwe;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rst_ld", load_data_out, 32'h0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_bus_error", bus_error, 1'b0);
        m_ph = 0;
        m_ld = '0;
        continue;
      end
      acc = memory_read_enable | memory_write_enable;
      chk("cyc_alu_out", ALU_result_out, ALU_result);
      chk("cyc_rd_out", rd_out, rd);
      chk("cyc_mux3_out", mux3_select_out, mux3_select);
      chk("cyc_addr", mem_addr, {ALU_result[31:2], 2'b00});
      chk("cyc_ld", load_data_out, m_ld);
      e_stall = 1'b0; e_mis = 1'b0; e_rv = 1'b0; e_be = 1'b0; e_rwe = regwrite_enable;
      if (m_ph == 0) begin
        flt     = m_fault(memory_read_enable, memory_write_enable, funct3, ALU_result[1:0]);
        e_stall = acc && !flt;
        e_mis   = acc && flt;
        e_rwe   = regwrite_enable && !e_mis;
        if (acc && !flt) begin
          m_ph = 1; m_cyc = 0; m_acc = 0; m_to = 0;
        end
      end else if (m_ph == 1) begin
        e_stall = 1'b1;
        e_rv    = !m_acc;
        chk("cyc_we", mem_we, memory_write_enable);
        chk("cyc_wstrb", mem_wstrb,
            memory_write_enable ? m_strb(funct3, ALU_result[1:0]) : 4'b0000);
        if (memory_write_enable) chk("cyc_wdata", mem_wdata, m_wdata(funct3, data2));
        m_cyc++;
        if (m_acc && mem_rvalid) begin
          if (memory_read_enable) m_ld = m_ext(funct3, ALU_result[1:0], mem_rdata);
          m_ph = 2; m_to = 0;
        end else if (m_cyc == int'(T)) begin
          m_ph = 2; m_to = 1;
        end else if (!m_acc && mem_req_ready) begin
          m_acc = 1;
        end
      end else begin
        e_be  = m_to;
        e_rwe = regwrite_enable && !m_to;
        m_ph  = 0;
      end
      chk("cyc_stall", stall, e_stall);
      chk("cyc_misaligned", misaligned, e_mis);
      chk("cyc_req_valid", mem_req_valid, e_rv);
      chk("cyc_bus_error", bus_error, e_be);
      chk("cyc_rwe_out", regwrite_enable_out, e_rwe);
    end
  end

  // Present one instruction, hold it while stalled, check hand-computed results.
  task automatic run_op(input string nm, input logic re, input logic we, input logic rwe,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d2,
                        input logic [31:0] rdata, input int rl, input int vl,
                        input int e_stalls, input logic [31:0] e_ld, input logic e_rwe,
                        input logic e_mis, input logic e_be, input logic chk_bus,
                        input logic [31:0] e_addr, input logic [31:0] e_wd,
                        input logic [3:0] e_ws);
    int n;
    bit seen, ended;
    logic [31:0] c_addr, c_wd;
    logic [3:0]  c_ws;
    logic        c_we;
    memory_read_enable = re; memory_write_enable = we; regwrite_enable = rwe;
    funct3 = f3; ALU_result = addr; data2 = d2; mem_rdata = rdata;
    rd = 5'(addr[4:0] ^ 5'h11); mux3_select = addr[2];
    cfg_rl = rl; cfg_vl = vl;
    n = 0; seen = 0; ended = 0;
    c_addr = '0; c_wd = '0; c_ws = '0; c_we = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      #3;
      if (mem_req_valid && !seen) begin
        seen = 1; c_addr = mem_addr; c_wd = mem_wdata; c_ws = mem_wstrb; c_we = mem_we;
      end
      if (!stall) begin
        ended = 1;
        break;
      end
      n++;
    end
    if (!ended) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_hang: stall still high after 64 cycles", nm);
    end
    chk({nm, "_stall_cycles"}, n, e_stalls);
    chk({nm, "_ld"}, load_data_out, e_ld);
    chk({nm, "_rwe_out"}, regwrite_enable_out, e_rwe);
    chk({nm, "_misaligned"}, misaligned, e_mis);
    chk({nm, "_bus_error"}, bus_error, e_be);
    if (chk_bus) begin
      chk({nm, "_req_seen"}, seen, 1'b1);
      chk({nm, "_addr"}, c_addr, e_addr);
      chk({nm, "_we"}, c_we, 1'b1);
      chk({nm, "_wdata"}, c_wd, e_wd);
      chk({nm, "_wstrb"}, c_ws, e_ws);
    end
    @(posedge clk);
    #1;
  endtask

  // Directed sequence.
  initial begin
    rst_n = 1'b0;
    ALU_result = '0; data2 = '0; funct3 = '0; rd = '0; mem_rdata = '0;
    memory_read_enable = 0; memory_write_enable = 0; regwrite_enable = 0; mux3_select = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_valid", mem_req_valid, 1'b0);
    chk("reset_ld", load_data_out, 32'h0);
    chk("reset_bus_error", bus_error, 1'b0);
    chk("reset_misaligned", misaligned, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("nop", 0, 0, 1, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 0,
           0, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    run_op("lw", 1, 0, 1, 3'b010, 32'h0000_0100, 32'h0, 32'h8765_4321, 0, 0,
           3, 32'h8765_4321, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    run_op("lb", 1, 0, 1, 3'b000, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 0,
           3, 32'hFFFF_FF80, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    run_op("lbu", 1, 0, 1, 3'b100, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 0,
           3, 32'h0000_0080, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    run_op("lh", 1, 0, 1, 3'b001, 32'h0000_0102, 32'h0, 32'h8012_3456, 1, 1,
           5, 32'hFFFF_8012, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    run_op("lhu", 1, 0, 1, 3'b101, 32'h0000_0100, 32'h0, 32'h8012_8456, 0, 0,
           3, 32'h0000_8456, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    run_op("sh", 0, 1, 0, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1, 2,
           6, 32'h0000_8456, 0, 0, 0, 1, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100);
    run_op("sb", 0, 1, 0, 3'b000, 32'h0000_0301, 32'hDEAD_BEEF, 32'h0, 0, 0,
           3, 32'h0000_8456, 0, 0, 0, 1, 32'h0000_0300, 32'hEFEF_EFEF, 4'b0010);
    run_op("sw", 0, 1, 0, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, 0, 0,
           3, 32'h0000_8456, 0, 0, 0, 1, 32'h0000_0400, 32'hCAFE_F00D, 4'b1111);
    run_op("lw_mis", 1, 0, 1, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 0,
           0, 32'h0000_8456, 0, 1, 0, 0, 32'h0, 32'h0, 4'h0);
    run_op("sw_mis", 0, 1, 1, 3'b010, 32'h0000_0402, 32'h1, 32'h0, 0, 0,
           0, 32'h0000_8456, 0, 1, 0, 0, 32'h0, 32'h0, 4'h0);
    run_op("ld_f011", 1, 0, 1, 3'b011, 32'h0000_0108, 32'h0, 32'h0, 0, 0,
           0, 32'h0000_8456, 0, 1, 0, 0, 32'h0, 32'h0, 4'h0);
    run_op("st_f100", 0, 1, 1, 3'b100, 32'h0000_0108, 32'h0, 32'h0, 0, 0,
           0, 32'h0000_8456, 0, 1, 0, 0, 32'h0, 32'h0, 4'h0);
    run_op("lw_timeout", 1, 0, 1, 3'b010, 32'h0000_0500, 32'h0, 32'h1111_1111, -1, 0,
           9, 32'h0000_8456, 0, 0, 1, 0, 32'h0, 32'h0, 4'h0);
    run_op("nop2", 0, 0, 1, 3'b010, 32'h0000_0505, 32'h0, 32'h0, 0, 0,
           0, 32'h0000_8456, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Reset while waiting for a read response, then a stray response.
    memory_read_enable = 1; memory_write_enable = 0; regwrite_enable = 1;
    funct3 = 3'b010; ALU_result = 32'h0000_0700; mem_rdata = 32'h5555_5555;
    cfg_rl = 0; cfg_vl = 20;
    repeat (2) @(posedge clk);
    #1;
    chk("resp_stall", stall, 1'b1);
    chk("resp_req_valid", mem_req_valid, 1'b0);
    rst_n = 1'b0;
    memory_read_enable = 0; regwrite_enable = 0;
    #1;
    chk("midrst_ld", load_data_out, 32'h0);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_req_valid", mem_req_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray_rv = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    stray_rv = 1'b0;
    chk("stray_ld", load_data_out, 32'h0);
    chk("stray_stall", stall, 1'b0);
    run_op("lw_after_rst", 1, 0, 1, 3'b010, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 0, 0,
           3, 32'h0BAD_F00D, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
